// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//
// Purpose:
//   Performs a W-bit addition (W = N*WORDS) by time-multiplexing an external
//   N-bit ripple-carry adder. Operands are latched in IDLE, then one N-bit
//   slice is pushed through the adder per clock in BUSY (least significant
//   slice first, carry chained through a register), and the assembled sum,
//   final carry and signed-overflow flag are held in DONE until consumed.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid / in_ready operand-set handshake (in_ready only in IDLE)
//   op_a, op_b, op_cin  W-bit operands and carry-in
//   add_a, add_b,       slice and carry driven to the external adder
//   add_cin             (all zero outside BUSY)
//   add_sum, add_cout   combinational result of the external adder
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   result, cout,       assembled sum, carry out of bit W-1 and
//   overflow            two's complement overflow flag

module multiword_add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 op_cin,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W     = N * WORDS;
  // A single-slice configuration still needs a 1-bit index so the
  // part-selects below stay legal.
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             cin_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  // Handshake flags decode directly from the state register, so they change
  // only on a clock edge or the asynchronous reset.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Sequencer: latch operands in IDLE, walk the slices in BUSY storing each
  // partial sum and chaining the carry, then hold the result in DONE until
  // the consumer takes it. The final slice also yields cout and overflow;
  // overflow is judged from the operand sign bits and the top bit of the
  // last slice's sum, which is bit W-1 of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            cin_q <= op_cin;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          result[int'(idx)*N +: N] <= add_sum;
          carry_q                  <= add_cout;
          if (idx == LAST_IDX) begin
            cout     <= add_cout;
            overflow <= (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Adder drive: the current slice of each operand plus either the latched
  // carry-in (first slice) or the carry produced by the previous slice.
  // Everything is forced to zero outside BUSY so the adder sees quiet inputs.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == BUSY) begin
      add_a   = a_q[int'(idx)*N +: N];
      add_b   = b_q[int'(idx)*N +: N];
      add_cin = (idx == '0) ? cin_q : carry_q;
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer
//
// Purpose:
//   Directed self-checking bench for multiword_add_sequencer. The main
//   instance uses N=4, WORDS=4 (16-bit operands); a second instance uses
//   N=8, WORDS=1 to cover the single-slice case. Each instance has a
//   behavioural N-bit adder attached to its add_* ports.
//
// Ports: none (top-level bench).

module tb_multiword_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        overflow;

  logic        s1_in_valid;
  logic        s1_in_ready;
  logic [7:0]  s1_op_a;
  logic [7:0]  s1_op_b;
  logic        s1_op_cin;
  logic [7:0]  s1_add_a;
  logic [7:0]  s1_add_b;
  logic        s1_add_cin;
  logic [7:0]  s1_add_sum;
  logic        s1_add_cout;
  logic        s1_out_valid;
  logic        s1_out_ready;
  logic [7:0]  s1_result;
  logic        s1_cout;
  logic        s1_overflow;

  int n_compared;
  int n_mismatched;

  multiword_add_sequencer #(.N(4), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  multiword_add_sequencer #(.N(8), .WORDS(1)) dut_single (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .op_a      (s1_op_a),
    .op_b      (s1_op_b),
    .op_cin    (s1_op_cin),
    .add_a     (s1_add_a),
    .add_b     (s1_add_b),
    .add_cin   (s1_add_cin),
    .add_sum   (s1_add_sum),
    .add_cout  (s1_add_cout),
    .out_valid (s1_out_valid),
    .out_ready (s1_out_ready),
    .result    (s1_result),
    .cout      (s1_cout),
    .overflow  (s1_overflow)
  );

  // Attached ripple-carry adders, purely combinational.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign {s1_add_cout, s1_add_sum} =
    {1'b0, s1_add_a} + {1'b0, s1_add_b} + {8'b0, s1_add_cin};

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set while in IDLE, then wait (bounded) for out_valid.
  // lat counts cycles from the accept edge; trace records add_cin seen in
  // each BUSY cycle so carry chaining can be checked.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, output int lat,
                               output logic [7:0] trace);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    step();
    in_valid = 1'b0;
    lat      = 0;
    trace    = '0;
    while (!out_valid && lat < 20) begin
      if (lat < 8) trace[lat] = add_cin;
      step();
      lat++;
    end
  endtask

  // Consume the held result and confirm the block returns to IDLE.
  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_ovalid_after"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_iready_after"}, 32'(in_ready), 32'd1);
  endtask

  // Run a directed transaction and check the full result set.
  task automatic runVector(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           input logic [15:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf);
    int         lat;
    logic [7:0] trace;
    applyStimulus(a, b, cin, lat, trace);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_result"}, 32'(result), 32'(exp_sum));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    releaseResult(tag);
  endtask

  logic [15:0] vec_a [4];
  logic [15:0] vec_b [4];
  logic        vec_c [4];

  initial begin
    int         lat;
    logic [7:0] trace;
    int         k;
    int         done_n;
    int         last_acc;
    logic       was_ready;
    logic [16:0] model;
    logic        model_ovf;

    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    op_a         = '0;
    op_b         = '0;
    op_cin       = 1'b0;
    out_ready    = 1'b0;
    s1_in_valid  = 1'b0;
    s1_op_a      = '0;
    s1_op_b      = '0;
    s1_op_cin    = 1'b0;
    s1_out_ready = 1'b0;

    // Reset state, sampled while rst_n is still low.
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_add_a", 32'({add_a, add_b, add_cin}), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // Carry ripples across slices 0 and 1 only.
    applyStimulus(16'h00FF, 16'h0001, 1'b0, lat, trace);
    checkOutput("v1_latency", 32'(lat), 32'd4);
    checkOutput("v1_result", 32'(result), 32'h0100);
    checkOutput("v1_cout", 32'(cout), 32'd0);
    checkOutput("v1_overflow", 32'(overflow), 32'd0);
    checkOutput("v1_cin_trace", 32'(trace), 32'b0110);
    checkOutput("v1_add_quiet_done", 32'({add_a, add_b, add_cin}), 32'd0);
    releaseResult("v1");

    // Full carry chain with carry-out; then signed overflow.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, lat, trace);
    checkOutput("v2_result", 32'(result), 32'h0000);
    checkOutput("v2_cout", 32'(cout), 32'd1);
    checkOutput("v2_overflow", 32'(overflow), 32'd0);
    checkOutput("v2_cin_trace", 32'(trace), 32'b1110);
    releaseResult("v2");
    runVector("v3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Carry-in appears on add_cin in the first BUSY cycle only.
    applyStimulus(16'h1234, 16'h4321, 1'b1, lat, trace);
    checkOutput("v4_result", 32'(result), 32'h5556);
    checkOutput("v4_cout", 32'(cout), 32'd0);
    checkOutput("v4_overflow", 32'(overflow), 32'd0);
    checkOutput("v4_cin_trace", 32'(trace), 32'b0001);
    releaseResult("v4");

    // Result held in DONE while the consumer stalls and in_valid pulses.
    applyStimulus(16'h8001, 16'h8002, 1'b0, lat, trace);
    checkOutput("hold_result0", 32'(result), 32'h0003);
    checkOutput("hold_cout", 32'(cout), 32'd1);
    checkOutput("hold_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      step();
      checkOutput("hold_result", 32'(result), 32'h0003);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    releaseResult("hold");
    step();
    checkOutput("hold_pulses_dropped", 32'(in_ready), 32'd1);

    // Reset during the second BUSY cycle, partial slice already written.
    in_valid = 1'b1;
    op_a     = 16'hFFFF;
    op_b     = 16'hFFFF;
    op_cin   = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
    checkOutput("abort_flags", 32'({cout, overflow}), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    runVector("post_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back operation with in_valid held high and out_ready high.
    vec_a[0] = 16'hA5A5; vec_b[0] = 16'h5A5A; vec_c[0] = 1'b0;
    vec_a[1] = 16'hFFFF; vec_b[1] = 16'hFFFF; vec_c[1] = 1'b1;
    vec_a[2] = 16'h8000; vec_b[2] = 16'h7FFF; vec_c[2] = 1'b1;
    vec_a[3] = 16'h4000; vec_b[3] = 16'h4000; vec_c[3] = 1'b0;
    out_ready = 1'b1;
    k         = 0;
    done_n    = 0;
    last_acc  = -1;
    for (int cyc = 0; cyc < 200 && done_n < 4; cyc++) begin
      if (out_valid) begin
        model     = {1'b0, vec_a[done_n]} + {1'b0, vec_b[done_n]} +
                    {16'b0, vec_c[done_n]};
        model_ovf = (vec_a[done_n][15] == vec_b[done_n][15]) &&
                    (model[15] != vec_a[done_n][15]);
        checkOutput("b2b_result", 32'(result), 32'(model[15:0]));
        checkOutput("b2b_cout", 32'(cout), 32'(model[16]));
        checkOutput("b2b_overflow", 32'(overflow), 32'(model_ovf));
        done_n++;
      end
      was_ready = in_ready;
      if (in_ready) begin
        if (k < 4) begin
          op_a     = vec_a[k];
          op_b     = vec_b[k];
          op_cin   = vec_c[k];
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
      if (was_ready && in_valid) begin
        if (last_acc >= 0) checkOutput("b2b_gap", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        k++;
      end
    end
    checkOutput("b2b_count", 32'(done_n), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    // Single-slice instance: one BUSY cycle, then DONE.
    s1_in_valid = 1'b1;
    s1_op_a     = 8'h7F;
    s1_op_b     = 8'h01;
    s1_op_cin   = 1'b0;
    step();
    s1_in_valid = 1'b0;
    checkOutput("s1_busy_add_a", 32'(s1_add_a), 32'h7F);
    checkOutput("s1_busy_out_valid", 32'(s1_out_valid), 32'd0);
    step();
    checkOutput("s1_out_valid", 32'(s1_out_valid), 32'd1);
    checkOutput("s1_result", 32'(s1_result), 32'h80);
    checkOutput("s1_cout", 32'(s1_cout), 32'd0);
    checkOutput("s1_overflow", 32'(s1_overflow), 32'd1);
    s1_out_ready = 1'b1;
    step();
    s1_out_ready = 1'b0;
    checkOutput("s1_ovalid_after", 32'(s1_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: slice width in bits, equal to the width of the attached N-bit ripple-carry adder.
REQ-002 SHALL have parameter WORDS, default 4: number of slices; operand width W = N*WORDS.
REQ-003 SHALL use one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts an operand set.
REQ-008 op_a  input  W  operand A, unsigned or two's complement.
REQ-009 op_b  input  W  operand B.
REQ-010 op_cin  input  1  carry-in to slice 0.
REQ-011 add_a  output  N  slice of A driven to the adder.
REQ-012 add_b  output  N  slice of B driven to the adder.
REQ-013 add_cin  output  1  carry driven to the adder.
REQ-014 add_sum  input  N  adder sum, combinational from add_a/add_b/add_cin.
REQ-015 add_cout  input  1  adder carry-out.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer takes the result.
REQ-018 result  output  W  assembled sum.
REQ-019 cout  output  1  carry out of the final slice.
REQ-020 overflow  output  1  signed overflow flag.

Function
REQ-021 SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-022 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-023 IDLE: when in_valid=1, SHALL latch op_a, op_b and op_cin, clear the slice index idx to 0, and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-024 BUSY: add_a = A[idx*N +: N], add_b = B[idx*N +: N], add_cin = latched op_cin when idx=0, otherwise the carry register.
REQ-025 BUSY, at each edge: result[idx*N +: N] <= add_sum, carry register <= add_cout, idx <= idx+1.
REQ-026 When idx=WORDS-1 at the edge, SHALL store slice, cout <= add_cout, overflow <= (A[W-1]==B[W-1]) && (add_sum[N-1]!=A[W-1]), and go to DONE.
REQ-027 Latency: out_valid SHALL rise exactly WORDS cycles after the accept edge; one slice is processed per cycle; there are no idle bubbles.
REQ-028 DONE: result, cout and overflow SHALL be held stable; on out_ready=1 the block SHALL go to IDLE, and out_valid SHALL be 0 the next cycle.
REQ-029 in_valid in BUSY or DONE SHALL be ignored; no operand SHALL be captured outside IDLE.
REQ-030 add_a, add_b and add_cin SHALL be 0 outside BUSY.
REQ-031 idx SHALL be sized ceil(log2(WORDS)), with a minimum of 1 bit, and SHALL NOT wrap within an operation.
REQ-032 WORDS=1 SHALL work: a single BUSY cycle.
REQ-033 Arithmetic SHALL be modulo 2^W; cout SHALL be the true carry out of bit W-1.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, idx=0, carry register=0, result=0, cout=0, overflow=0, out_valid=0, add_* = 0, and in_ready=1.
REQ-035 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation with no partial result retained; the first accept after rst_n rises SHALL start a clean operation.

Verification (N=4, WORDS=4, adder model attached)
REQ-036 op_a=0x00FF, op_b=0x0001, op_cin=0 -> result=0x0100, cout=0, overflow=0, out_valid 4 cycles after accept.
REQ-037 0xFFFF + 0x0001, op_cin=0 -> result=0x0000, cout=1, overflow=0; 0x7FFF + 0x0001 -> result=0x8000, cout=0, overflow=1.
REQ-038 0x1234 + 0x4321, op_cin=1 -> result=0x5556, cout=0; add_cin=1 is observed in the first BUSY cycle only.
REQ-039 out_ready=0 for 5 cycles in DONE, with new in_valid pulses -> result held, in_ready=0, pulses dropped; out_ready=1 -> IDLE next cycle.
REQ-040 rst_n pulled low in BUSY cycle 2 -> all outputs 0 immediately; after release, 0x0001 + 0x0001 -> result=0x0002.
REQ-041 Back-to-back: in_valid held high and out_ready=1 -> a new accept every WORDS+2 cycles, and each result matches a reference model.
